vtx_txn_sequencer: RTL

VTX_TXN_SEQUENCER -- requirements
Module: vtx_txn_sequencer

---
 rtl/vtx_txn_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vtx_txn_sequencer.sv
// Per-instruction memory transaction recorder: captures one COP instruction
// with up to NTXN request/response pairs and reports it as a single record.
module vtx_txn_sequencer #(
   parameter int unsigned NTXN = 4
) (
   input  logic                 vtx_clk,
   input  logic                 vtx_reset,
   input  logic                 instr_start,
   input  logic [31:0]          instr_enc,
   input  logic [31:0]          instr_rs1,
   input  logic                 instr_done,
   input  logic [2:0]           instr_result,
   input  logic                 instr_wen,
   input  logic [4:0]           instr_waddr,
   input  logic [31:0]          instr_wdata,
   input  logic                 mem_cen,
   input  logic                 mem_wen,
   input  logic [31:0]          mem_addr,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_ben,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [31:0]          mem_rdata,
   input  logic                 mem_error,
   output logic                 vtx_valid,
   output logic [31:0]          vtx_instr_enc,
   output logic [31:0]          vtx_instr_rs1,
   output logic [2:0]           vtx_instr_result,
   output logic                 vtx_instr_wen,
   output logic [4:0]           vtx_instr_waddr,
   output logic [31:0]          vtx_instr_wdata,
   output logic [NTXN-1:0]      vtx_mem_cen,
   output logic [NTXN-1:0]      vtx_mem_wen,
   output logic [NTXN-1:0]      vtx_mem_error,
   output logic [32*NTXN-1:0]   vtx_mem_addr,
   output logic [32*NTXN-1:0]   vtx_mem_wdata,
   output logic [32*NTXN-1:0]   vtx_mem_rdata,
   output logic [4*NTXN-1:0]    vtx_mem_ben,
   output logic                 vtx_overflow,
   output logic                 vtx_proto_err
);

   localparam int unsigned CW = $clog2(NTXN + 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_RSP, REPORT} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
   logic                valid_q, valid_d, ovf_q, ovf_d, proto_q, proto_d;
   logic [31:0]         enc_q, enc_d, rs1_q, rs1_d, iwdata_q, iwdata_d;
   logic [2:0]          result_q, result_d;
   logic                iwen_q, iwen_d;
   logic [4:0]          waddr_q, waddr_d;
   logic [NTXN-1:0]     mcen_q, mcen_d, mwen_q, mwen_d, merr_q, merr_d;
   logic [32*NTXN-1:0]  maddr_q, maddr_d, mwdata_q, mwdata_d, mrdata_q, mrdata_d;
   logic [4*NTXN-1:0]   mben_q, mben_d;

   logic                accept, req_en, rsp_en, perr, capture;
   logic [CW-1:0]       req_idx, rsp_idx;

   assign accept  = mem_cen & mem_gnt;
   assign cnt_inc = (cnt_q == CW'(NTXN)) ? cnt_q : cnt_q + CW'(1);

   always_comb begin
      state_d  = state_q;   cnt_d    = cnt_q;    valid_d  = 1'b0;
      ovf_d    = ovf_q;     enc_d    = enc_q;    rs1_d    = rs1_q;
      result_d = result_q;  iwen_d   = iwen_q;   waddr_d  = waddr_q;
      iwdata_d = iwdata_q;  mcen_d   = mcen_q;   mwen_d   = mwen_q;
      merr_d   = merr_q;    maddr_d  = maddr_q;  mwdata_d = mwdata_q;
      mrdata_d = mrdata_q;  mben_d   = mben_q;
      req_en   = 1'b0;      req_idx  = '0;       rsp_en   = 1'b0;
      rsp_idx  = '0;        perr     = 1'b0;     capture  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) perr = 1'b1;
            if (instr_start) begin
               enc_d    = instr_enc;  rs1_d    = instr_rs1;
               result_d = '0;         iwen_d   = 1'b0;
               waddr_d  = '0;         iwdata_d = '0;
               mcen_d   = '0;         mwen_d   = '0;   merr_d   = '0;
               maddr_d  = '0;         mwdata_d = '0;   mrdata_d = '0;
               mben_d   = '0;         cnt_d    = '0;   ovf_d    = 1'b0;
               state_d  = ACTIVE;
               if (instr_done) capture = 1'b1;
            end
         end
         ACTIVE: begin
            if (instr_start || mem_rvalid) perr = 1'b1;
            if (accept) begin
               req_en  = 1'b1;
               req_idx = cnt_q;
               state_d = WAIT_RSP;
            end
            if (instr_done) capture = 1'b1;
         end
         WAIT_RSP: begin
            if (instr_start) perr = 1'b1;
            // A same-cycle response retires the old slot before the new request lands in the next one
            if (mem_rvalid) begin
               rsp_en  = 1'b1;
               rsp_idx = cnt_q;
               cnt_d   = cnt_inc;
               state_d = ACTIVE;
               if (accept) begin
                  req_en  = 1'b1;
                  req_idx = cnt_inc;
                  state_d = WAIT_RSP;
               end
            end else if (accept) begin
               perr = 1'b1;
            end
            if (instr_done) begin
               capture = 1'b1;
               if (!mem_rvalid) perr = 1'b1;
            end
         end
         REPORT: begin
            if (instr_start || accept) perr = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (capture) begin
         result_d = instr_result;  iwen_d   = instr_wen;
         waddr_d  = instr_waddr;   iwdata_d = instr_wdata;
         state_d  = REPORT;        valid_d  = 1'b1;
      end

      for (int unsigned i = 0; i < NTXN; i++) begin
         if (rsp_en && rsp_idx == CW'(i)) begin
            mrdata_d[i*32 +: 32] = mem_rdata;
            merr_d[i]            = mem_error;
         end
         if (req_en && req_idx == CW'(i)) begin
            mcen_d[i]            = 1'b1;
            mwen_d[i]            = mem_wen;
            maddr_d[i*32 +: 32]  = mem_addr;
            mwdata_d[i*32 +: 32] = mem_wdata;
            mben_d[i*4 +: 4]     = mem_ben;
         end
      end
      if (req_en && req_idx == CW'(NTXN)) ovf_d = 1'b1;
      proto_d = proto_q | perr;
   end

   always_ff @(posedge vtx_clk or posedge vtx_reset) begin
      if (vtx_reset) begin
         state_q  <= IDLE;  cnt_q    <= '0;  valid_q  <= 1'b0;
         ovf_q    <= 1'b0;  proto_q  <= 1'b0;
         enc_q    <= '0;    rs1_q    <= '0;  result_q <= '0;
         iwen_q   <= 1'b0;  waddr_q  <= '0;  iwdata_q <= '0;
         mcen_q   <= '0;    mwen_q   <= '0;  merr_q   <= '0;
         maddr_q  <= '0;    mwdata_q <= '0;  mrdata_q <= '0;
         mben_q   <= '0;
      end else begin
         state_q  <= state_d;   cnt_q    <= cnt_d;    valid_q  <= valid_d;
         ovf_q    <= ovf_d;     proto_q  <= proto_d;
         enc_q    <= enc_d;     rs1_q    <= rs1_d;    result_q <= result_d;
         iwen_q   <= iwen_d;    waddr_q  <= waddr_d;  iwdata_q <= iwdata_d;
         mcen_q   <= mcen_d;    mwen_q   <= mwen_d;   merr_q   <= merr_d;
         maddr_q  <= maddr_d;   mwdata_q <= mwdata_d; mrdata_q <= mrdata_d;
         mben_q   <= mben_d;
      end
   end

   assign vtx_valid        = valid_q;
   assign vtx_instr_enc    = enc_q;
   assign vtx_instr_rs1    = rs1_q;
   assign vtx_instr_result = result_q;
   assign vtx_instr_wen    = iwen_q;
   assign vtx_instr_waddr  = waddr_q;
   assign vtx_instr_wdata  = iwdata_q;
   assign vtx_mem_cen      = mcen_q;
   assign vtx_mem_wen      = mwen_q;
   assign vtx_mem_error    = merr_q;
   assign vtx_mem_addr     = maddr_q;
   assign vtx_mem_wdata    = mwdata_q;
   assign vtx_mem_rdata    = mrdata_q;
   assign vtx_mem_ben      = mben_q;
   assign vtx_overflow     = ovf_q;
   assign vtx_proto_err    = proto_q;

endmodule
